leaf_send_port: RTL
===================

Name: leaf_send_port

Overview:
- Transmit half of a leaf output port: accepts 32-bit words from a user operator output stream via the vld/ack handshake.
- Buffers the words, wraps each into a 49-bit BFT packet and sends it toward a configured destination leaf/port.
- Credit-based: never sends more packets than the destination input BRAM can hold. Credits are replenished by freespace-update packets from the receiving end.
- Also decodes config packets that set the destination.

Parameters:
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, user word width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, address/sequence field width.
- NUM_BRAM_ADDR_BITS, 7, log2 of receiver buffer depth; initial credits = 2^NUM_BRAM_ADDR_BITS.
- FIFO_DEPTH_BITS, 4, log2 of local word FIFO depth (16).
- SELF_LEAF, 0, this leaf's address; incoming packets with another leaf field are ignored.
- SELF_PORT, 2, this output port's index; matched against the port field of control packets.

Ports:
- clk_bft  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- din_leaf_user2interface  input  32  user data word.
- vld_user2interface  input  1  user word valid.
- ack_interface2user  output  1  word accepted; a transfer occurs in any cycle with vld & ack.
- din_leaf_bft2interface  input  49  incoming BFT packet (config/credit), bit 48 = valid.
- dout_leaf_interface2bft  output  49  outgoing packet, bit 48 = valid.
- out_ready  input  1  BFT accepts the outgoing packet this cycle.
- configured  output  1  destination has been set.
- credits  output  8  current credit count (NUM_BRAM_ADDR_BITS+1).

Behaviour:
- Packet format, MSB to LSB: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload.
- Reset values: dout = 0, ack_interface2user = 0, configured = 0, credits = 128, seq = 0, FIFO empty, state UNCONFIG, dst_leaf/dst_port = 0.
- ack_interface2user = !fifo_full.
  - Driven from registered FIFO occupancy only, never from vld.
  - Forced 0 while reset is high.
- FIFO is first-word-fall-through. A push and a pop in the same cycle while full is legal only when the pop frees the slot; ack is still low in that cycle, so no push happens.
- Incoming packet decode applies only when bit48 = 1, leaf == SELF_LEAF and port == 0 or 1; all other packets are dropped.
  - Config (port 0), payload[31:28] == SELF_PORT: dst_leaf = payload[8:4], dst_port = payload[3:0], state goes to RUN. A reconfig in RUN takes effect for the next packet launched; a packet already in the output register is not altered.
  - Credit (port 1), payload[31:28] == SELF_PORT: credits += payload[7:0], saturating at 2^NUM_BRAM_ADDR_BITS.
- States:
  - UNCONFIG: words are accepted and buffered; nothing is sent. Goes to RUN on a config packet.
  - RUN: sending is enabled. It stays in RUN until reset.
- Launch condition: state RUN, FIFO not empty, credits != 0, and the output register is empty or out_ready is high.
- On launch, in the next cycle:
  - dout = {1, dst_leaf, dst_port, seq, fifo_head}.
  - FIFO pops, seq increments mod 128, credits decrements by 1.
- Output hold: dout stays stable with valid = 1 until a cycle with out_ready = 1. In the cycle after acceptance dout valid = 0 unless a back-to-back launch occurred. Back-to-back packets sustain 1 packet/cycle while out_ready = 1.
- Credit update and launch in the same cycle: credits = sat(credits + inc) - 1.
- Latency: a user word accepted at cycle t, with FIFO previously empty and credits available, appears on dout at cycle t+2.
- credits == 0: no launch; FIFO fills, then ack drops. Sending resumes in the cycle after a credit packet is registered.
- Reset mid-operation: all state returns to reset values in the following cycle. Buffered words and any in-flight output are discarded, and dout valid = 0.

Test Plan:
- Reset, then 3 user words 0x11, 0x22, 0x33 with no config -> ack = 1, dout valid stays 0, configured = 0. Then config payload 0x20000055 (port 2, leaf 5, dport 5) -> 3 packets with leaf = 5, port = 5, addr 0, 1, 2, payloads 0x11, 0x22, 0x33 in order, credits = 125.
- Configured; send 130 words with out_ready = 1 and no credit packets -> exactly 128 packets, addr wraps 127 -> 0. Credits reach 0 and the remaining 2 words stay buffered. Credit packet with inc 64 -> the 2 words are sent, credits = 62.
- out_ready = 0 for 5 cycles with a packet pending -> dout held bit-identical. FIFO fills to 16, then ack = 0 while vld = 1, with no word lost or duplicated once out_ready returns.
- Credit packet with inc 64 in the same cycle as a launch at credits = 100 -> credits = 127. A further inc 64 -> saturates at 128.
- Packets with the wrong leaf, port 3, or payload[31:28] != SELF_PORT -> no change to config or credits.
- Reset asserted with 5 words buffered and a packet held -> the next cycle shows dout = 0, credits = 128, configured = 0, ack = 0 during reset and ack = 1 after.

Source files
------------

// File: rtl/leaf_send_port_if.sv
// Handshake/bus bundle for the leaf transmit port: user word stream in,
// BFT packet stream out, plus the BFT control/credit packet input.
interface leaf_send_port_if #(
  parameter int PACKET_BITS  = 49,
  parameter int PAYLOAD_BITS = 32
);
  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic                    vld_user2interface;
  logic                    ack_interface2user;
  logic [PACKET_BITS-1:0]  din_leaf_bft2interface;
  logic [PACKET_BITS-1:0]  dout_leaf_interface2bft;
  logic                    out_ready;

  modport master (
    output din_leaf_user2interface, vld_user2interface,
    output din_leaf_bft2interface, out_ready,
    input  ack_interface2user, dout_leaf_interface2bft
  );

  modport slave (
    input  din_leaf_user2interface, vld_user2interface,
    input  din_leaf_bft2interface, out_ready,
    output ack_interface2user, dout_leaf_interface2bft
  );
endinterface

// File: rtl/leaf_send_port.sv
// Transmit half of a leaf output port. User words are buffered in a small
// FWFT FIFO, wrapped into BFT packets and launched toward a configured
// destination, gated by credits that mirror free space at the receiver.
module leaf_send_port #(
  parameter int PACKET_BITS        = 49,
  parameter int PAYLOAD_BITS       = 32,
  parameter int NUM_LEAF_BITS      = 5,
  parameter int NUM_PORT_BITS      = 4,
  parameter int NUM_ADDR_BITS      = 7,
  parameter int NUM_BRAM_ADDR_BITS = 7,
  parameter int FIFO_DEPTH_BITS    = 4,
  parameter int SELF_LEAF          = 0,
  parameter int SELF_PORT          = 2
) (
  input  logic                        clk_bft,
  input  logic                        reset,
  leaf_send_port_if.slave             bus,
  output logic                        configured,
  output logic [NUM_BRAM_ADDR_BITS:0] credits
);
  localparam int CW       = NUM_BRAM_ADDR_BITS + 1;
  localparam int DEPTH    = 1 << FIFO_DEPTH_BITS;
  localparam int CRED_MAX = 1 << NUM_BRAM_ADDR_BITS;

  typedef struct packed {
    logic                     vld;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
    logic [NUM_ADDR_BITS-1:0] addr;
    logic [PAYLOAD_BITS-1:0]  payload;
  } pkt_t;

  typedef enum logic {UNCONFIG, RUN} state_t;

  state_t                     state_q, state_d;
  pkt_t                       in_pkt, out_q;
  logic [NUM_LEAF_BITS-1:0]   dst_leaf;
  logic [NUM_PORT_BITS-1:0]   dst_port;
  logic [NUM_ADDR_BITS-1:0]   seq;

  logic [PAYLOAD_BITS-1:0]    mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_BITS:0]   cnt;
  logic                       full, empty, push, launch;

  logic                       hit, cfg_hit, cred_hit;
  logic [CW-1:0]              inc, cred_sat, credits_d;
  logic [CW:0]                cred_sum;
  logic                       unused_bits;

  assign in_pkt      = bus.din_leaf_bft2interface;
  assign unused_bits = ^in_pkt;

  // control packets addressed to this leaf and to this output port
  assign hit = in_pkt.vld && (in_pkt.leaf == NUM_LEAF_BITS'(SELF_LEAF)) &&
               (in_pkt.payload[PAYLOAD_BITS-1 -: 4] == 4'(SELF_PORT));
  assign cfg_hit  = hit && (in_pkt.port == NUM_PORT_BITS'(0));
  assign cred_hit = hit && (in_pkt.port == NUM_PORT_BITS'(1));

  assign full  = (cnt == (FIFO_DEPTH_BITS+1)'(DEPTH));
  assign empty = (cnt == '0);
  // ack comes only from registered occupancy so it never loops back on vld
  assign bus.ack_interface2user = !reset && !full;
  assign push = bus.vld_user2interface && bus.ack_interface2user;

  assign bus.dout_leaf_interface2bft = out_q;
  assign configured = (state_q == RUN);

  // next state and launch decision
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      UNCONFIG: if (cfg_hit) state_d = RUN;
      RUN:      launch = !empty && (credits != '0) &&
                         (!out_q.vld || bus.out_ready);
      default:  state_d = UNCONFIG;
    endcase
  end

  // credit arithmetic: saturate the refill first, then charge the launch
  always_comb begin
    inc       = cred_hit ? in_pkt.payload[CW-1:0] : '0;
    cred_sum  = {1'b0, credits} + {1'b0, inc};
    cred_sat  = (cred_sum > (CW+1)'(CRED_MAX)) ? CW'(CRED_MAX) : cred_sum[CW-1:0];
    credits_d = cred_sat - CW'(launch);
  end

  // FIFO storage; contents need no reset since occupancy guards reads
  always_ff @(posedge clk_bft) begin
    if (push) mem[wr_ptr] <= bus.din_leaf_user2interface;
  end

  // state, FIFO pointers, credits, destination and output register
  always_ff @(posedge clk_bft) begin
    if (reset) begin
      state_q  <= UNCONFIG;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      credits  <= CW'(CRED_MAX);
      seq      <= '0;
      dst_leaf <= '0;
      dst_port <= '0;
      out_q    <= '0;
    end else begin
      state_q <= state_d;
      credits <= credits_d;
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (launch) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (FIFO_DEPTH_BITS+1)'(push) - (FIFO_DEPTH_BITS+1)'(launch);
      // reconfig only affects packets launched after this edge
      if (cfg_hit) begin
        dst_leaf <= in_pkt.payload[NUM_PORT_BITS +: NUM_LEAF_BITS];
        dst_port <= in_pkt.payload[NUM_PORT_BITS-1:0];
      end
      if (launch) begin
        out_q <= '{vld: 1'b1, leaf: dst_leaf, port: dst_port,
                   addr: seq, payload: mem[rd_ptr]};
        seq   <= seq + 1'b1;
      end else if (bus.out_ready) begin
        out_q <= '0;
      end
    end
  end
endmodule
